ciphertext_collector: RTL and testbench
=======================================

// Module: ciphertext_collector
// PURPOSE
// - Downstream stage of the three-stage Caesar cipher core. Captures each ciphertext char the core
//   flags ready into a DEPTH-entry FIFO and re-issues it on a valid/ready stream to the consumer.
// - Keeps saturating statistics: chars accepted, key-error cycles, plaintext-error cycles, chars dropped.
// PARAMETERS
// - DEPTH   16  FIFO entries; power of two, >= 2
// - CNT_W   16  width of each statistics counter
// PORTS
// - Interface (decided): one clock; reset is asynchronous and active-high.
// - clk                        in   1       clock; all state updates on rising edge
// - rst                        in   1       async active-high reset
// - ciphertext_char            in   8       char from cipher core (registered at its output)
// - flag_ciphertext_ready      in   1       cipher core char valid this cycle (push request)
// - err_invalid_key_shift_num  in   1       cipher core key error flag
// - err_invalid_ptxt_char      in   1       cipher core plaintext error flag
// - stats_clear                in   1       sync clear of all counters and the overflow flag
// - out_char                   out  8       FIFO head char
// - out_valid                  out  1       out_char valid; FIFO not empty
// - out_ready                  in   1       consumer accepts out_char when out_valid && out_ready
// - fifo_level                 out  $clog2(DEPTH)+1  entries held, 0..DEPTH
// - fifo_full                  out  1       fifo_level == DEPTH
// - overflow                   out  1       sticky: a push was dropped
// - cnt_chars                  out  CNT_W   chars written into the FIFO
// - cnt_err_key                out  CNT_W   cycles with err_invalid_key_shift_num = 1
// - cnt_err_ptxt               out  CNT_W   cycles with err_invalid_ptxt_char = 1
// - cnt_dropped                out  CNT_W   pushes lost because the FIFO was full
// BEHAVIOUR
// - Reset: out_char=8'h00, out_valid=0, fifo_level=0, fifo_full=0, overflow=0, all counters=0.
//   Rd/wr pointers are cleared. Memory contents are don't-care.
// - Reset mid-operation flushes all entries. The consumer must drop any beat in flight.
// - Push = flag_ciphertext_ready. Pop = out_valid && out_ready.
// - Pointers: wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally (DEPTH-1 -> 0).
//   Level is tracked by a separate counter.
// - Push while not full: write ciphertext_char at wr_ptr, wr_ptr++, cnt_chars++.
// - Push while full with no pop that cycle: char is dropped, overflow<=1, cnt_dropped++.
//   Pointers and level are unchanged.
// - Push and pop in the same cycle while full: both are performed, level stays DEPTH, no drop.
// - Push and pop in the same cycle while 0 < level < DEPTH: level is unchanged.
// - Push while empty: no bypass. out_valid rises the cycle after the push (latency 1 clk).
//   out_char = mem[rd_ptr] on that same cycle.
// - Pop: rd_ptr++ and level--. The next entry (if any) appears the following cycle.
//   out_valid drops when level reaches 0.
// - Stall: while out_valid && !out_ready, out_char and out_valid are held stable.
// - Errors: each cycle err_invalid_key_shift_num=1 increments cnt_err_key.
//   Each cycle err_invalid_ptxt_char=1 increments cnt_err_ptxt. Both may increment together.
//   Error flags never push; the core holds flag_ciphertext_ready=0 on error.
// - Counters saturate at 2**CNT_W-1 and never wrap.
// - stats_clear: all counters and overflow go to 0 next cycle; the FIFO is untouched.
//   An increment in the same cycle as stats_clear is discarded (clear wins).
// - fifo_full and fifo_level are registered and reflect state after the current edge.
// TESTING
// - Reset release, push 'K','h','o' on 3 consecutive cycles, out_ready=1
//   -> out_char K,h,o on cycles 2,3,4 and cnt_chars=3.
// - out_ready=0, push 17 chars with DEPTH=16 -> fifo_full=1, overflow=1, cnt_dropped=1.
//   First 16 chars are then drained in order.
// - Full FIFO, push and pop in the same cycle, repeated 40 cycles -> level stays 16, overflow stays 0.
//   Pointers wrap with output order preserved.
// - Hold err_invalid_key_shift_num=1 and err_invalid_ptxt_char=1 for 5 cycles
//   -> cnt_err_key=5, cnt_err_ptxt=5, fifo_level=0.
// - CNT_W=4 with 20 pushes (out_ready=1) -> cnt_chars saturates at 15.
//   Then stats_clear pulse -> all counters 0.
// - Assert rst for 1 cycle with 6 entries queued -> out_valid=0 and fifo_level=0 immediately (async).
//   The next push appears after 1 cycle.

Source files
------------

// File: rtl/ciphertext_collector.sv
// Output stage of the Caesar cipher core: buffers ciphertext chars in a FIFO
// and reissues them on a valid/ready stream, with saturating statistics.
module ciphertext_collector #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               ciphertext_char,
    input  logic                     flag_ciphertext_ready,
    input  logic                     err_invalid_key_shift_num,
    input  logic                     err_invalid_ptxt_char,
    input  logic                     stats_clear,
    output logic [7:0]               out_char,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     fifo_full,
    output logic                     overflow,
    output logic [CNT_W-1:0]         cnt_chars,
    output logic [CNT_W-1:0]         cnt_err_key,
    output logic [CNT_W-1:0]         cnt_err_ptxt,
    output logic [CNT_W-1:0]         cnt_dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [7:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             r_full;
    logic             r_valid;
    logic             r_overflow;
    logic [CNT_W-1:0] r_cnt_chars;
    logic [CNT_W-1:0] r_cnt_err_key;
    logic [CNT_W-1:0] r_cnt_err_ptxt;
    logic [CNT_W-1:0] r_cnt_dropped;

    logic             w_push;
    logic             w_pop;
    logic             w_wr;
    logic             w_drop;
    logic [LW-1:0]    w_level_nxt;

    assign w_push = flag_ciphertext_ready;
    assign w_pop  = r_valid && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_wr   = w_push && (!r_full || w_pop);
    assign w_drop = w_push && r_full && !w_pop;

    always_comb begin
        w_level_nxt = r_level;
        unique case ({w_wr, w_pop})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= ciphertext_char;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == FULL_LVL);
            r_valid <= (w_level_nxt != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (stats_clear) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // Statistics saturate at all-ones; a clear in the same cycle wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_chars    <= '0;
            r_cnt_err_key  <= '0;
            r_cnt_err_ptxt <= '0;
            r_cnt_dropped  <= '0;
        end else if (stats_clear) begin
            r_cnt_chars    <= '0;
            r_cnt_err_key  <= '0;
            r_cnt_err_ptxt <= '0;
            r_cnt_dropped  <= '0;
        end else begin
            if (w_wr && (r_cnt_chars != '1)) begin
                r_cnt_chars <= r_cnt_chars + 1'b1;
            end
            if (err_invalid_key_shift_num && (r_cnt_err_key != '1)) begin
                r_cnt_err_key <= r_cnt_err_key + 1'b1;
            end
            if (err_invalid_ptxt_char && (r_cnt_err_ptxt != '1)) begin
                r_cnt_err_ptxt <= r_cnt_err_ptxt + 1'b1;
            end
            if (w_drop && (r_cnt_dropped != '1)) begin
                r_cnt_dropped <= r_cnt_dropped + 1'b1;
            end
        end
    end

    assign out_char     = r_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign out_valid    = r_valid;
    assign fifo_level   = r_level;
    assign fifo_full    = r_full;
    assign overflow     = r_overflow;
    assign cnt_chars    = r_cnt_chars;
    assign cnt_err_key  = r_cnt_err_key;
    assign cnt_err_ptxt = r_cnt_err_ptxt;
    assign cnt_dropped  = r_cnt_dropped;

endmodule

// File: tb/tb_ciphertext_collector.sv
// Directed bench for ciphertext_collector: vector table plus hand-written
// sequences for overflow, full-rate streaming, saturation and async reset.
module tb_ciphertext_collector;

    logic        clk;
    logic        rst;
    logic [7:0]  ciphertext_char;
    logic        flag_ciphertext_ready;
    logic        err_invalid_key_shift_num;
    logic        err_invalid_ptxt_char;
    logic        stats_clear;
    logic        out_ready;

    logic [7:0]  out_char;
    logic        out_valid;
    logic [4:0]  fifo_level;
    logic        fifo_full;
    logic        overflow;
    logic [15:0] cnt_chars;
    logic [15:0] cnt_err_key;
    logic [15:0] cnt_err_ptxt;
    logic [15:0] cnt_dropped;

    logic [7:0]  s_out_char;
    logic        s_out_valid;
    logic [4:0]  s_fifo_level;
    logic        s_fifo_full;
    logic        s_overflow;
    logic [3:0]  s_cnt_chars;
    logic [3:0]  s_cnt_err_key;
    logic [3:0]  s_cnt_err_ptxt;
    logic [3:0]  s_cnt_dropped;

    int n_checks = 0;
    int n_errors = 0;

    ciphertext_collector #(.DEPTH(16), .CNT_W(16)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .ciphertext_char           (ciphertext_char),
        .flag_ciphertext_ready     (flag_ciphertext_ready),
        .err_invalid_key_shift_num (err_invalid_key_shift_num),
        .err_invalid_ptxt_char     (err_invalid_ptxt_char),
        .stats_clear               (stats_clear),
        .out_char                  (out_char),
        .out_valid                 (out_valid),
        .out_ready                 (out_ready),
        .fifo_level                (fifo_level),
        .fifo_full                 (fifo_full),
        .overflow                  (overflow),
        .cnt_chars                 (cnt_chars),
        .cnt_err_key               (cnt_err_key),
        .cnt_err_ptxt              (cnt_err_ptxt),
        .cnt_dropped               (cnt_dropped)
    );

    ciphertext_collector #(.DEPTH(16), .CNT_W(4)) dut4 (
        .clk                       (clk),
        .rst                       (rst),
        .ciphertext_char           (ciphertext_char),
        .flag_ciphertext_ready     (flag_ciphertext_ready),
        .err_invalid_key_shift_num (err_invalid_key_shift_num),
        .err_invalid_ptxt_char     (err_invalid_ptxt_char),
        .stats_clear               (stats_clear),
        .out_char                  (s_out_char),
        .out_valid                 (s_out_valid),
        .out_ready                 (out_ready),
        .fifo_level                (s_fifo_level),
        .fifo_full                 (s_fifo_full),
        .overflow                  (s_overflow),
        .cnt_chars                 (s_cnt_chars),
        .cnt_err_key               (s_cnt_err_key),
        .cnt_err_ptxt              (s_cnt_err_ptxt),
        .cnt_dropped               (s_cnt_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       push;
        logic [7:0] ch;
        logic       rdy;
        logic       e_valid;
        logic [7:0] e_char;
        logic [4:0] e_level;
    } vec_t;

    vec_t tbl [9];
    byte  q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        stats_clear = 1'b1;
        step();
        stats_clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ciphertext_char = 8'h00;
        flag_ciphertext_ready = 1'b0;
        err_invalid_key_shift_num = 1'b0;
        err_invalid_ptxt_char = 1'b0;
        stats_clear = 1'b0;
        out_ready = 1'b0;

        tbl[0] = '{1'b1, "K", 1'b1, 1'b1, "K",   5'd1};
        tbl[1] = '{1'b1, "h", 1'b1, 1'b1, "h",   5'd1};
        tbl[2] = '{1'b1, "o", 1'b1, 1'b1, "o",   5'd1};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0};
        tbl[4] = '{1'b1, "A", 1'b0, 1'b1, "A",   5'd1};
        tbl[5] = '{1'b1, "B", 1'b0, 1'b1, "A",   5'd2};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b1, "A", 5'd2};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, "B", 5'd1};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0};

        repeat (2) step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_char", 32'(out_char), 32'h00);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_cnt", 32'(cnt_chars | cnt_err_key | cnt_err_ptxt | cnt_dropped), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            flag_ciphertext_ready = tbl[i].push;
            ciphertext_char = tbl[i].ch;
            out_ready = tbl[i].rdy;
            step();
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_char", i), 32'(out_char), 32'(tbl[i].e_char));
            chk($sformatf("tbl%0d_level", i), 32'(fifo_level), 32'(tbl[i].e_level));
            if (i == 3) chk("tbl_cnt3", 32'(cnt_chars), 32'd3);
        end
        flag_ciphertext_ready = 1'b0;
        out_ready = 1'b0;
        chk("tbl_cnt5", 32'(cnt_chars), 32'd5);

        // Overflow: 17 pushes into a stalled 16-entry FIFO.
        clear_stats();
        for (int i = 0; i < 17; i++) begin
            flag_ciphertext_ready = 1'b1;
            ciphertext_char = 8'(8'h61 + i);
            step();
            if (i == 15) begin
                chk("ovf_full16", 32'(fifo_full), 32'd1);
                chk("ovf_lvl16", 32'(fifo_level), 32'd16);
                chk("ovf_flag16", 32'(overflow), 32'd0);
            end
        end
        flag_ciphertext_ready = 1'b0;
        chk("ovf_full", 32'(fifo_full), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_dropped", 32'(cnt_dropped), 32'd1);
        chk("ovf_chars", 32'(cnt_chars), 32'd16);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("drain%0d_char", i), 32'(out_char), 32'(8'(8'h61 + i)));
            step();
        end
        out_ready = 1'b0;
        chk("drain_level", 32'(fifo_level), 32'd0);
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_ovf_sticky", 32'(overflow), 32'd1);

        // Full-rate streaming through a full FIFO: pointers wrap.
        clear_stats();
        chk("clr_ovf", 32'(overflow), 32'd0);
        q.delete();
        for (int i = 0; i < 16; i++) begin
            flag_ciphertext_ready = 1'b1;
            ciphertext_char = 8'(8'h30 + i);
            q.push_back(byte'(8'h30 + i));
            step();
        end
        chk("stream_full", 32'(fifo_full), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            ciphertext_char = 8'(8'h40 + k);
            chk($sformatf("stream%0d_char", k), 32'(out_char), 32'(8'(q[0])));
            step();
            void'(q.pop_front());
            q.push_back(byte'(8'h40 + k));
            chk($sformatf("stream%0d_lvl", k), 32'(fifo_level), 32'd16);
        end
        flag_ciphertext_ready = 1'b0;
        chk("stream_ovf", 32'(overflow), 32'd0);
        chk("stream_drop", 32'(cnt_dropped), 32'd0);
        chk("stream_chars", 32'(cnt_chars), 32'd56);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("sdrain%0d", i), 32'(out_char), 32'(8'(q[0])));
            void'(q.pop_front());
            step();
        end
        out_ready = 1'b0;
        chk("sdrain_level", 32'(fifo_level), 32'd0);

        // Error flags count per cycle and never push.
        clear_stats();
        err_invalid_key_shift_num = 1'b1;
        err_invalid_ptxt_char = 1'b1;
        repeat (5) step();
        err_invalid_key_shift_num = 1'b0;
        err_invalid_ptxt_char = 1'b0;
        chk("err_key", 32'(cnt_err_key), 32'd5);
        chk("err_ptxt", 32'(cnt_err_ptxt), 32'd5);
        chk("err_level", 32'(fifo_level), 32'd0);
        chk("err_chars", 32'(cnt_chars), 32'd0);

        // Clear in the same cycle as an accepted push: clear wins.
        flag_ciphertext_ready = 1'b1;
        ciphertext_char = "X";
        stats_clear = 1'b1;
        step();
        flag_ciphertext_ready = 1'b0;
        stats_clear = 1'b0;
        chk("clrwin_chars", 32'(cnt_chars), 32'd0);
        chk("clrwin_key", 32'(cnt_err_key), 32'd0);
        chk("clrwin_level", 32'(fifo_level), 32'd1);
        chk("clrwin_char", 32'(out_char), 32'(8'h58));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Saturation on the narrow-counter instance.
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            flag_ciphertext_ready = 1'b1;
            ciphertext_char = 8'(8'h20 + i);
            step();
        end
        flag_ciphertext_ready = 1'b0;
        step();
        out_ready = 1'b0;
        chk("sat_chars4", 32'(s_cnt_chars), 32'd15);
        chk("sat_chars16", 32'(cnt_chars), 32'd20);
        chk("sat_level4", 32'(s_fifo_level), 32'd0);
        clear_stats();
        chk("sat_clr", 32'(s_cnt_chars | s_cnt_err_key | s_cnt_err_ptxt | s_cnt_dropped), 32'd0);
        chk("sat_clr_ovf", 32'(s_overflow), 32'd0);

        // Asynchronous reset with entries queued.
        for (int i = 0; i < 6; i++) begin
            flag_ciphertext_ready = 1'b1;
            ciphertext_char = 8'(8'h70 + i);
            step();
        end
        flag_ciphertext_ready = 1'b0;
        chk("ar_pre_level", 32'(fifo_level), 32'd6);
        rst = 1'b1;
        #2;
        chk("ar_valid", 32'(out_valid), 32'd0);
        chk("ar_level", 32'(fifo_level), 32'd0);
        chk("ar_char", 32'(out_char), 32'h00);
        step();
        rst = 1'b0;
        flag_ciphertext_ready = 1'b1;
        ciphertext_char = "Z";
        chk("ar_post_valid0", 32'(out_valid), 32'd0);
        step();
        flag_ciphertext_ready = 1'b0;
        chk("ar_post_valid", 32'(out_valid), 32'd1);
        chk("ar_post_char", 32'(out_char), 32'(8'h5A));
        chk("ar_post_level", 32'(fifo_level), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
